spi_channel_router: RTL and testbench
=====================================

SPI_CHANNEL_ROUTER -- requirements
Module: spi_channel_router

Interface
REQ-001 SHALL have parameter nbits, default 32, meaning upstream val/rdy message width.
REQ-002 SHALL have parameter num_channels, default 4, meaning downstream channel count; legal values 2, 4, 8.
REQ-003 SHALL derive localparams: abits = log2(num_channels); pbits = nbits - abits (payload width).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-low reset (asserted at 0).
REQ-005 SHALL have port loopthrough_sel  in  num_channels  per-channel loopback enable.
REQ-006 SHALL have ports upstream_req_val/msg/rdy  in/in[nbits]/out  requests from the SPI minion adapter; msg[nbits-1:pbits] is the channel address.
REQ-007 SHALL have ports upstream_resp_val/msg/rdy  out/out[nbits]/in  responses to the minion adapter.
REQ-008 SHALL have ports downstream_req_val/msg/rdy  out[N]/out[N*pbits]/in[N]  per-channel requests; channel i uses msg slice [i*pbits +: pbits].
REQ-009 SHALL have ports downstream_resp_val/msg/rdy  in[N]/in[N*pbits]/out[N]  per-channel responses, sliced the same way.

Function
REQ-010 SHALL route requests combinationally: for address a, downstream_req_val[a] = upstream_req_val and not loopthrough_sel[a]; payload = upstream_req_msg[pbits-1:0]; all other downstream_req_val = 0.
REQ-011 SHALL drive upstream_req_rdy = downstream_req_rdy[a] when loopthrough_sel[a]=0, else "loop buffer a empty".
REQ-012 SHALL give each channel a one-entry loop buffer; when loopthrough_sel[a]=1 a request fire writes the payload to buffer a and sets it full.
REQ-013 SHALL define per-channel response source i = loop buffer i when full; otherwise downstream_resp i when loopthrough_sel[i]=0; otherwise none.
REQ-014 SHALL hold downstream_resp_rdy[i] = 0 while loopthrough_sel[i]=1 or loop buffer i is full.
REQ-015 SHALL drain a full loop buffer after loopthrough_sel is deasserted, before accepting downstream responses on that channel.
REQ-016 SHALL select one valid source per cycle with a round-robin arbiter; after granting channel g, priority order starts at g+1 (mod num_channels).
REQ-017 SHALL register the granted response in a one-entry output register as {channel address, payload}; upstream_resp_val = register full.
REQ-018 SHALL let the output register load when empty or when upstream_resp_val and upstream_resp_rdy are both 1 in the same cycle, so back-to-back responses sustain one per cycle.
REQ-019 SHALL grant only when the output register can load; the arbiter pointer SHALL advance only on a grant.
REQ-020 SHALL have latency: downstream_resp fire at edge t -> upstream_resp_val=1 after edge t; loopback request fire at edge t -> upstream_resp_val=1 after edge t+1.
REQ-021 SHALL keep upstream_resp_msg stable while upstream_resp_val=1 and upstream_resp_rdy=0.
REQ-022 SHALL allow, in one cycle, a loop buffer write on channel a and a drain of a different channel.

Reset
REQ-023 SHALL on reset=0 asynchronously clear all loop buffers, clear the output register (upstream_resp_val=0), and set arbiter priority to channel 0.
REQ-024 SHALL drop all in-flight entries on reset mid-operation; combinational outputs follow inputs with empty state.

Configuration
REQ-025 SHALL, with SPI_CHANNEL_ROUTER_PARITY_EN defined, add output resp_parity [1] = XOR reduction of upstream_resp_msg, registered alongside the output register, reset value 0.
REQ-026 SHALL, without SPI_CHANNEL_ROUTER_PARITY_EN, omit the resp_parity port and logic; all other behaviour identical.

Structure
REQ-027 SHALL place abits/pbits derivation functions and the response-entry typedef {addr, payload} in package spi_router_pkg.
REQ-028 SHALL implement the arbiter as sub-module spi_router_rr_arbiter (parameter num_channels; req vector in, one-hot grant out, enable input).

Verification (nbits=32, num_channels=4, abits=2, pbits=30)
REQ-029 SHALL check request 0x8000_0123 with sel=0, downstream_req_rdy[2]=1 -> downstream_req_val[2]=1, payload 0x0000_0123, same cycle.
REQ-030 SHALL check sel[1]=1, request 0x4000_00AA -> upstream_resp_msg 0x4000_00AA two edges later; a second request to channel 1 stalls (rdy=0) until drain.
REQ-031 SHALL check channels 0,1,3 responding every cycle with upstream_resp_rdy=1 -> grant order 0,1,3,0,1,3; one response per cycle.
REQ-032 SHALL check upstream_resp_rdy=0 for 5 cycles with a full output register -> message held stable, downstream_resp_rdy all 0, no loss.
REQ-033 SHALL check reset=0 pulsed while loop buffer 3 is full and output register valid -> upstream_resp_val=0 immediately; no stale response after release.
REQ-034 SHALL check with SPI_CHANNEL_ROUTER_PARITY_EN a response 0xC000_0007 -> resp_parity=1 (five 1 bits).

Source files
------------

// File: rtl/spi_router_pkg.sv
// Shared helpers for the SPI channel router: address/payload width
// derivation and the response-entry layout {channel address, payload}.
package spi_router_pkg;

    function automatic int f_abits(input int n);
        return $clog2(n);
    endfunction

    function automatic int f_pbits(input int nbits, input int n);
        return nbits - f_abits(n);
    endfunction

    localparam int DEF_NBITS    = 32;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_ABITS    = f_abits(DEF_CHANNELS);
    localparam int DEF_PBITS    = f_pbits(DEF_NBITS, DEF_CHANNELS);

    // Upstream response word as seen by the minion adapter.
    typedef struct packed {
        logic [DEF_ABITS-1:0] addr;
        logic [DEF_PBITS-1:0] payload;
    } resp_entry_t;

endpackage

// File: rtl/spi_router_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among i_req when i_en is high.
// Ports: i_clk, i_rst_n (async, active-low), i_en, i_req[N], o_gnt[N].
module spi_router_rr_arbiter
    import spi_router_pkg::*;
#(
    parameter int num_channels = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [num_channels-1:0] i_req,
    output logic [num_channels-1:0] o_gnt
);

    localparam int abits = f_abits(num_channels);

    // r_ptr is the highest-priority channel for the next grant.
    logic [abits-1:0] r_ptr;
    logic [abits-1:0] w_idx;
    logic [abits-1:0] w_gidx;
    logic             w_found;

    // Scan from r_ptr upward; abits-wide addition wraps modulo N.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < num_channels; k++) begin
            w_idx = r_ptr + abits'(k);
            if (!w_found && i_en && i_req[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        if (w_found) begin
            o_gnt[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_gidx + abits'(1);
        end
    end

endmodule

// File: rtl/spi_channel_router.sv
// Routes SPI minion requests to N channels (or per-channel loop buffers)
// and merges channel responses upstream through a round-robin arbiter
// into a one-entry output register.
// Ports: clk, reset (async active-low), loopthrough_sel[N],
//   upstream_req_*/upstream_resp_* (val/rdy, nbits),
//   downstream_req_*/downstream_resp_* (val/rdy per channel, pbits each).
// Option: SPI_CHANNEL_ROUTER_PARITY_EN adds registered resp_parity.
module spi_channel_router
    import spi_router_pkg::*;
#(
    parameter int nbits        = 32,
    parameter int num_channels = 4,
    localparam int abits       = f_abits(num_channels),
    localparam int pbits       = f_pbits(nbits, num_channels)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_channels-1:0]       loopthrough_sel,
    input  logic                          upstream_req_val,
    input  logic [nbits-1:0]              upstream_req_msg,
    output logic                          upstream_req_rdy,
    output logic                          upstream_resp_val,
    output logic [nbits-1:0]              upstream_resp_msg,
    input  logic                          upstream_resp_rdy,
    output logic [num_channels-1:0]       downstream_req_val,
    output logic [num_channels*pbits-1:0] downstream_req_msg,
    input  logic [num_channels-1:0]       downstream_req_rdy,
    input  logic [num_channels-1:0]       downstream_resp_val,
    input  logic [num_channels*pbits-1:0] downstream_resp_msg,
    output logic [num_channels-1:0]       downstream_resp_rdy
`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
    ,
    output logic                          resp_parity
`endif
);

    logic [abits-1:0]                   w_addr;
    logic [pbits-1:0]                   w_payload;
    logic                               w_req_fire;
    logic                               w_lb_wr;
    logic                               w_load;
    logic [num_channels-1:0]            w_src_val;
    logic [num_channels-1:0][pbits-1:0] w_src_data;
    logic [num_channels-1:0]            w_gnt;
    logic [abits-1:0]                   w_gidx;
    logic [pbits-1:0]                   w_gdata;
    logic [nbits-1:0]                   w_entry;

    logic [num_channels-1:0]            r_lb_full;
    logic [num_channels-1:0][pbits-1:0] r_lb_data;
    logic                               r_out_full;
    logic [nbits-1:0]                   r_out_msg;

    assign w_addr    = upstream_req_msg[nbits-1 -: abits];
    assign w_payload = upstream_req_msg[pbits-1:0];

    always_comb begin
        downstream_req_val         = '0;
        downstream_req_val[w_addr] = upstream_req_val
                                   & ~loopthrough_sel[w_addr];
    end

    // Payload is broadcast; only the addressed channel sees val.
    assign downstream_req_msg = {num_channels{w_payload}};

    assign upstream_req_rdy = loopthrough_sel[w_addr]
                            ? ~r_lb_full[w_addr]
                            : downstream_req_rdy[w_addr];

    assign w_req_fire = upstream_req_val & upstream_req_rdy;
    assign w_lb_wr    = w_req_fire & loopthrough_sel[w_addr];

    // Output register may take a new entry when empty or draining now.
    assign w_load = ~r_out_full | upstream_resp_rdy;

    // A full loop buffer always wins over live responses on its channel,
    // so it drains even after loopthrough_sel drops.
    always_comb begin
        w_src_val  = '0;
        w_src_data = '0;
        for (int i = 0; i < num_channels; i++) begin
            w_src_val[i]  = r_lb_full[i]
                          | (~loopthrough_sel[i] & downstream_resp_val[i]);
            w_src_data[i] = r_lb_full[i]
                          ? r_lb_data[i]
                          : downstream_resp_msg[i*pbits +: pbits];
        end
    end

    spi_router_rr_arbiter #(
        .num_channels (num_channels)
    ) u_arb (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_load),
        .i_req   (w_src_val),
        .o_gnt   (w_gnt)
    );

    // Accept a live response only when it is the granted source.
    always_comb begin
        downstream_resp_rdy = '0;
        for (int i = 0; i < num_channels; i++) begin
            downstream_resp_rdy[i] = w_gnt[i]
                                   & ~r_lb_full[i]
                                   & ~loopthrough_sel[i];
        end
    end

    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < num_channels; i++) begin
            if (w_gnt[i]) begin
                w_gidx  = abits'(i);
                w_gdata = w_src_data[i];
            end
        end
    end

    assign w_entry = {w_gidx, w_gdata};

    // Write and drain never hit the same channel in one cycle: a write
    // needs the buffer empty, a drain needs it full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lb_full <= '0;
            r_lb_data <= '0;
        end else begin
            for (int i = 0; i < num_channels; i++) begin
                if (w_lb_wr && (w_addr == abits'(i))) begin
                    r_lb_full[i] <= 1'b1;
                    r_lb_data[i] <= w_payload;
                end else if (w_gnt[i] && r_lb_full[i]) begin
                    r_lb_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_full <= 1'b0;
            r_out_msg  <= '0;
        end else if (w_load) begin
            r_out_full <= |w_gnt;
            if (|w_gnt) begin
                r_out_msg <= w_entry;
            end
        end
    end

    assign upstream_resp_val = r_out_full;
    assign upstream_resp_msg = r_out_msg;

`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load && (|w_gnt)) begin
            r_parity <= ^w_entry;
        end
    end

    assign resp_parity = r_parity;
`endif

endmodule

// File: tb/tb_spi_channel_router.sv
// Self-checking bench for spi_channel_router (nbits=32, 4 channels):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_spi_channel_router;
    import spi_router_pkg::*;

    localparam int NB = 32;
    localparam int NC = 4;
    localparam int PB = 30;

    logic           clk = 1'b0;
    logic           reset;
    logic [NC-1:0]  sel;
    logic           req_val;
    logic [NB-1:0]  req_msg;
    logic           req_rdy;
    logic           resp_val;
    logic [NB-1:0]  resp_msg;
    logic           resp_rdy;
    logic [NC-1:0]  dq_val;
    logic [NC*PB-1:0] dq_msg;
    logic [NC-1:0]  dq_rdy;
    logic [NC-1:0]  dr_val;
    logic [NC*PB-1:0] dr_msg;
    logic [NC-1:0]  dr_rdy;
`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
    logic           par;
`endif

    always #5 clk = ~clk;

    spi_channel_router #(
        .nbits        (NB),
        .num_channels (NC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .loopthrough_sel     (sel),
        .upstream_req_val    (req_val),
        .upstream_req_msg    (req_msg),
        .upstream_req_rdy    (req_rdy),
        .upstream_resp_val   (resp_val),
        .upstream_resp_msg   (resp_msg),
        .upstream_resp_rdy   (resp_rdy),
        .downstream_req_val  (dq_val),
        .downstream_req_msg  (dq_msg),
        .downstream_req_rdy  (dq_rdy),
        .downstream_resp_val (dr_val),
        .downstream_resp_msg (dr_msg),
        .downstream_resp_rdy (dr_rdy)
`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
        ,
        .resp_parity         (par)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: loop buffers as simple slots, output register as
    // a single pending word, fairness tracked as "last channel granted".
    bit            m_lb_full [NC];
    logic [PB-1:0] m_lb_data [NC];
    bit            m_out_v;
    logic [NB-1:0] m_out_msg;
    int            m_last;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_lb_full[c] = 0;
            m_lb_data[c] = '0;
        end
        m_out_v   = 0;
        m_out_msg = '0;
        m_last    = NC - 1;
    endtask

    // Compare this cycle's outputs, then advance the model past the edge.
    task automatic eval();
        int            a;
        int            g;
        int            c;
        bit            can_load;
        logic          exp_req_rdy;
        logic [NC-1:0] exp_dq_val;
        logic [NC-1:0] exp_dr_rdy;
        logic [1:0]    ga;
        a = int'(req_msg[NB-1:PB]);
        exp_dq_val = '0;
        if (req_val && !sel[a]) exp_dq_val[a] = 1'b1;
        exp_req_rdy = sel[a] ? !m_lb_full[a] : dq_rdy[a];
        check("ds_req_val", dq_val, exp_dq_val);
        if (exp_dq_val != 0)
            check("ds_req_msg", dq_msg[a*PB +: PB], req_msg[PB-1:0]);
        check("us_req_rdy", req_rdy, exp_req_rdy);
        check("us_resp_val", resp_val, m_out_v);
        if (m_out_v) begin
            check("us_resp_msg", resp_msg, m_out_msg);
`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
            check("resp_parity", par, ^m_out_msg);
`endif
        end
        can_load = !m_out_v || resp_rdy;
        g = -1;
        if (can_load) begin
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (g < 0 && (m_lb_full[c] || (!sel[c] && dr_val[c])))
                    g = c;
            end
        end
        exp_dr_rdy = '0;
        if (g >= 0 && !m_lb_full[g]) exp_dr_rdy[g] = 1'b1;
        check("ds_resp_rdy", dr_rdy, exp_dr_rdy);
        if (can_load) begin
            if (g >= 0) begin
                ga = g[1:0];
                m_out_v = 1;
                if (m_lb_full[g]) begin
                    m_out_msg = {ga, m_lb_data[g]};
                    m_lb_full[g] = 0;
                end else begin
                    m_out_msg = {ga, dr_msg[g*PB +: PB]};
                end
                m_last = g;
            end else begin
                m_out_v = 0;
            end
        end
        if (req_val && exp_req_rdy && sel[a]) begin
            m_lb_full[a] = 1;
            m_lb_data[a] = req_msg[PB-1:0];
        end
    endtask

    task automatic tick();
        #1;
        eval();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sel      = '0;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;
        dq_rdy   = '0;
        dr_val   = '0;
        dr_msg   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int order [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        resp_entry_t e;
        logic [NC-1:0] one;
        idle_inputs();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_resp_val", resp_val, 1'b0);
        check("reset_dr_rdy", dr_rdy, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Direct route to channel 2.
        req_val = 1'b1;
        req_msg = 32'h8000_0123;
        dq_rdy  = 4'b0100;
        #1;
        check("route_val", dq_val, 4'b0100);
        check("route_payload", dq_msg[2*PB +: PB], 30'h0000_0123);
        check("route_rdy", req_rdy, 1'b1);
        tick();

        // Loopback on channel 1, second request stalls until drain.
        dq_rdy  = '0;
        sel     = 4'b0010;
        req_msg = 32'h4000_00AA;
        tick();
        req_msg = 32'h4000_00BB;
        #1;
        check("lb_stall_rdy", req_rdy, 1'b0);
        check("lb_not_yet", resp_val, 1'b0);
        tick();
        #1;
        check("lb_resp_val", resp_val, 1'b1);
        check("lb_resp_msg", resp_msg, 32'h4000_00AA);
        check("lb_rdy_again", req_rdy, 1'b1);
        tick();
        req_val = 1'b0;
        tick();
        #1;
        check("lb_second_msg", resp_msg, 32'h4000_00BB);
        tick();

        // Round robin over channels 0,1,3 from a fresh pointer.
        idle_inputs();
        do_reset();
        dr_val = 4'b1011;
        for (int c = 0; c < NC; c++)
            dr_msg[c*PB +: PB] = PB'(32'h100 + c);
        for (int i = 0; i < 6; i++) begin
            #1;
            one = '0;
            one[order[i]] = 1'b1;
            check("rr_grant", dr_rdy, one);
            if (i > 0) begin
                e = resp_msg;
                check("rr_val", resp_val, 1'b1);
                check("rr_addr", e.addr, order[i-1]);
            end
            tick();
        end

        // Backpressure: hold a full output register for 5 cycles.
        resp_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_val", resp_val, 1'b1);
            check("hold_msg", resp_msg, 32'hC000_0103);
            check("hold_dr_rdy", dr_rdy, 4'b0000);
            tick();
        end
        resp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Reset mid-operation with loop buffer 3 and output both full.
        dr_val   = '0;
        resp_rdy = 1'b0;
        sel      = 4'b1000;
        req_val  = 1'b1;
        req_msg  = 32'hC000_0055;
        tick();
        req_val = 1'b0;
        #1;
        check("pre_rst_val", resp_val, 1'b1);
        reset = 1'b0;
        #1;
        check("async_rst_val", resp_val, 1'b0);
        model_reset();
        @(negedge clk);
        reset    = 1'b1;
        sel      = '0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("no_stale", resp_val, 1'b0);
            tick();
        end

        // Response 0xC000_0007 from channel 3 (five set bits).
        dr_val = 4'b1000;
        dr_msg[3*PB +: PB] = 30'h7;
        tick();
        dr_val = '0;
        #1;
        check("par_msg", resp_msg, 32'hC000_0007);
`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
        check("par_bit", par, 1'b1);
`endif
        tick();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(15) == 0) sel = NC'($urandom());
            req_val  = 1'($urandom());
            req_msg  = $urandom();
            dq_rdy   = NC'($urandom());
            dr_val   = NC'($urandom());
            for (int c = 0; c < NC; c++)
                dr_msg[c*PB +: PB] = PB'($urandom());
            resp_rdy = ($urandom_range(3) != 0);
            if ($urandom_range(499) == 0) begin
                reset = 1'b0;
                #1;
                check("rand_rst_val", resp_val, 1'b0);
                model_reset();
                @(negedge clk);
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
